// File: rtl/compute_unit_pipe_pkg.sv
// Shared opcodes, instruction field positions, flag indices and register-use decode
// for the pipelined compute unit.
package compute_unit_pipe_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_CMP  = 4'hA;
  localparam logic [3:0] OP_MOV  = 4'hB;

  localparam int unsigned OP_LSB   = 12;
  localparam int unsigned TGT_LSB  = 8;
  localparam int unsigned SRC0_LSB = 4;
  localparam int unsigned SRC1_LSB = 0;
  localparam int unsigned IMM_LSB  = 0;

  localparam int unsigned FLG_Z = 0;
  localparam int unsigned FLG_N = 1;
  localparam int unsigned FLG_C = 2;

  typedef struct packed {
    logic tgt;
    logic src0;
    logic src1;
  } reg_use_t;

  // Which register-id fields an opcode actually consumes (for the illegal-id check).
  function automatic reg_use_t reg_use(input logic [3:0] op);
    reg_use_t u;
    u = '{tgt: 1'b0, src0: 1'b0, src1: 1'b0};
    case (op)
      OP_LOAD: u.tgt = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
        u.tgt  = 1'b1;
        u.src0 = 1'b1;
        u.src1 = 1'b1;
      end
      OP_NOT, OP_MOV: begin
        u.tgt  = 1'b1;
        u.src0 = 1'b1;
      end
      OP_CMP: begin
        u.src0 = 1'b1;
        u.src1 = 1'b1;
      end
      default: ;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/compute_unit_pipe_if.sv
// Instruction-in / result-out handshake bundle of the compute unit.
interface compute_unit_pipe_if #(
  parameter int unsigned DATA_W = 8
);
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [3:0]        res_reg;
  logic [2:0]        flags;
  logic              err_illegal;

  modport master (
    output instr_valid, instr, res_ready,
    input  instr_ready, res_valid, res_data, res_reg, flags, err_illegal
  );

  modport slave (
    input  instr_valid, instr, res_ready,
    output instr_ready, res_valid, res_data, res_reg, flags, err_illegal
  );
endinterface

// File: rtl/compute_unit_pipe_alu.sv
// Combinational execute stage: result, carry, RF write enable and illegal decode.
module compute_unit_pipe_alu
  import compute_unit_pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic [3:0]        op_i,
  input  logic [3:0]        tgt_i,
  input  logic [3:0]        src0_i,
  input  logic [3:0]        src1_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [7:0]        imm_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o,
  output logic              writes_rf_o,
  output logic              illegal_o
);
  localparam int unsigned ShW      = $clog2(DATA_W);
  localparam logic [4:0]  RegLimit = 5'(NUM_REGS);

  logic [DATA_W:0] add_ext, sub_ext, shl_ext, shr_ext;
  logic [ShW-1:0]  sh_amt;
  reg_use_t        uses;
  logic            bad_id;

  // Extra bit on each side captures carry/borrow and the last bit shifted out.
  assign sh_amt  = b_i[ShW-1:0];
  assign add_ext = {1'b0, a_i} + {1'b0, b_i};
  assign sub_ext = {1'b0, a_i} - {1'b0, b_i};
  assign shl_ext = {1'b0, a_i} << sh_amt;
  assign shr_ext = {a_i, 1'b0} >> sh_amt;

  assign uses   = reg_use(op_i);
  assign bad_id = (uses.tgt  & ({1'b0, tgt_i}  >= RegLimit))
                | (uses.src0 & ({1'b0, src0_i} >= RegLimit))
                | (uses.src1 & ({1'b0, src1_i} >= RegLimit));
  assign illegal_o = (op_i[3:2] == 2'b11) | bad_id;

  always_comb begin
    result_o    = '0;
    carry_o     = 1'b0;
    writes_rf_o = 1'b0;
    case (op_i)
      OP_LOAD: begin
        result_o    = DATA_W'(imm_i);
        writes_rf_o = 1'b1;
      end
      OP_ADD: begin
        {carry_o, result_o} = add_ext;
        writes_rf_o         = 1'b1;
      end
      OP_SUB: begin
        {carry_o, result_o} = sub_ext;
        writes_rf_o         = 1'b1;
      end
      OP_CMP: {carry_o, result_o} = sub_ext;
      OP_AND: begin
        result_o    = a_i & b_i;
        writes_rf_o = 1'b1;
      end
      OP_OR: begin
        result_o    = a_i | b_i;
        writes_rf_o = 1'b1;
      end
      OP_NOT: begin
        result_o    = ~a_i;
        writes_rf_o = 1'b1;
      end
      OP_XOR: begin
        result_o    = a_i ^ b_i;
        writes_rf_o = 1'b1;
      end
      OP_SHL: begin
        {carry_o, result_o} = shl_ext;
        writes_rf_o         = 1'b1;
      end
      OP_SHR: begin
        {result_o, carry_o} = shr_ext;
        writes_rf_o         = 1'b1;
      end
      OP_MOV: begin
        result_o    = a_i;
        writes_rf_o = 1'b1;
      end
      default: ;
    endcase
    if (illegal_o) writes_rf_o = 1'b0;
  end

endmodule

// File: rtl/compute_unit_pipe.sv
// Two-stage (issue, execute/writeback) compute unit with an internal register file
// and EX->issue operand forwarding.
module compute_unit_pipe
  import compute_unit_pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  compute_unit_pipe_if.slave bus_io
);
  localparam int unsigned IdxW = $clog2(NUM_REGS);

  logic [DATA_W-1:0] rf_q [NUM_REGS];

  logic              s1_valid_q, s1_valid_d;
  logic [3:0]        s1_op_q, s1_op_d, s1_tgt_q, s1_tgt_d;
  logic [3:0]        s1_src0_q, s1_src0_d, s1_src1_q, s1_src1_d;
  logic [7:0]        s1_imm_q, s1_imm_d;
  logic [DATA_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;

  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [3:0]        res_reg_q, res_reg_d;
  logic [2:0]        flags_q, flags_d;
  logic              err_q, err_d;

  logic [3:0]        in_op, in_tgt, in_src0, in_src1;
  logic [7:0]        in_imm;
  logic [DATA_W-1:0] alu_result, opnd_a, opnd_b;
  logic              alu_carry, alu_writes, alu_illegal;
  logic              advance, accept, fwd_en, rf_we, s1_emits;

  assign in_op   = bus_io.instr[OP_LSB +: 4];
  assign in_tgt  = bus_io.instr[TGT_LSB +: 4];
  assign in_src0 = bus_io.instr[SRC0_LSB +: 4];
  assign in_src1 = bus_io.instr[SRC1_LSB +: 4];
  assign in_imm  = bus_io.instr[IMM_LSB +: 8];

  compute_unit_pipe_alu #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_alu (
    .op_i        (s1_op_q),
    .tgt_i       (s1_tgt_q),
    .src0_i      (s1_src0_q),
    .src1_i      (s1_src1_q),
    .a_i         (s1_a_q),
    .b_i         (s1_b_q),
    .imm_i       (s1_imm_q),
    .result_o    (alu_result),
    .carry_o     (alu_carry),
    .writes_rf_o (alu_writes),
    .illegal_o   (alu_illegal)
  );

  // The whole pipe moves together; a full, unconsumed result stage blocks everything.
  assign advance            = ena & ~(res_valid_q & ~bus_io.res_ready);
  assign bus_io.instr_ready = rst_n & advance;
  assign accept             = bus_io.instr_valid & bus_io.instr_ready;

  // The instruction in EX writes the RF on the same edge the new one issues, so bypass it.
  assign fwd_en   = s1_valid_q & alu_writes;
  assign opnd_a   = (fwd_en && s1_tgt_q == in_src0) ? alu_result : rf_q[in_src0[IdxW-1:0]];
  assign opnd_b   = (fwd_en && s1_tgt_q == in_src1) ? alu_result : rf_q[in_src1[IdxW-1:0]];
  assign rf_we    = advance & fwd_en;
  assign s1_emits = s1_valid_q & ~alu_illegal & (s1_op_q != OP_NOP);

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_tgt_d    = s1_tgt_q;
    s1_src0_d   = s1_src0_q;
    s1_src1_d   = s1_src1_q;
    s1_imm_d    = s1_imm_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_reg_d   = res_reg_q;
    flags_d     = flags_q;
    err_d       = 1'b0;
    if (advance) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_op_d   = in_op;
        s1_tgt_d  = in_tgt;
        s1_src0_d = in_src0;
        s1_src1_d = in_src1;
        s1_imm_d  = in_imm;
        s1_a_d    = opnd_a;
        s1_b_d    = opnd_b;
      end
      res_valid_d = s1_emits;
      if (s1_emits) begin
        res_data_d     = alu_result;
        res_reg_d      = s1_tgt_q;
        flags_d[FLG_C] = alu_carry;
        flags_d[FLG_N] = alu_result[DATA_W-1];
        flags_d[FLG_Z] = ~|alu_result;
      end
      err_d = s1_valid_q & alu_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_tgt_q    <= '0;
      s1_src0_q   <= '0;
      s1_src1_q   <= '0;
      s1_imm_q    <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_reg_q   <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_tgt_q    <= s1_tgt_d;
      s1_src0_q   <= s1_src0_d;
      s1_src1_q   <= s1_src1_d;
      s1_imm_q    <= s1_imm_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_reg_q   <= res_reg_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[s1_tgt_q[IdxW-1:0]] <= alu_result;
    end
  end

  assign bus_io.res_valid   = res_valid_q;
  assign bus_io.res_data    = res_data_q;
  assign bus_io.res_reg     = res_reg_q;
  assign bus_io.flags       = flags_q;
  assign bus_io.err_illegal = err_q;

endmodule
